osd_spi_master: RTL and testbench



---
 rtl/osd_pkg.sv | 37 +++
 rtl/spi_tx_shift.sv | 68 ++++++
 rtl/osd_spi_master.sv | 160 ++++++++++++++++
 tb/tb_osd_spi_master.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : osd_pkg
// Brief    : OSD SPI command opcodes, cmd_op encodings and line geometry.
// Revision : 1.0 - initial release
// ============================================================================
package osd_pkg;

    localparam logic [7:0] OSD_CMD_WRITE  = 8'h20;
    // Enable/disable share one opcode; bit 0 selects enable.
    localparam logic [7:0] OSD_CMD_ENABLE = 8'h40;

    localparam int OSD_LINES      = 8;
    localparam int OSD_LINE_BYTES = 256;
    localparam int OSD_LINE_W     = $clog2(OSD_LINES);

    typedef enum logic [1:0] {
        OP_DISABLE  = 2'd0,
        OP_ENABLE   = 2'd1,
        OP_WRITE    = 2'd2,
        OP_RESERVED = 2'd3
    } osd_op_e;

    function automatic logic [7:0] osd_cmd_byte(input osd_op_e op,
                                                input logic [OSD_LINE_W-1:0] line);
        logic [7:0] b;
        case (op)
            OP_ENABLE: b = OSD_CMD_ENABLE | 8'h01;
            OP_WRITE:  b = OSD_CMD_WRITE | {{(8-OSD_LINE_W){1'b0}}, line};
            default:   b = OSD_CMD_ENABLE;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx_shift.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_tx_shift
// Brief    : 8-bit MSB-first shifter with SCK half-period divider.
// Revision : 1.0 - initial release
// ============================================================================
module spi_tx_shift #(
    parameter int SCK_DIV = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       sck,
    output logic       sdo,
    output logic       half_end,
    output logic       last_bit
);

    localparam int                 c_CNT_W   = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit;
    logic               r_active;
    logic               r_sck;

    assign half_end = r_active && (r_cnt == c_CNT_MAX);
    assign last_bit = (r_bit == 3'd7);
    assign sck      = r_sck;
    // Zeros shift in, so the data line rests low once a byte has gone out.
    assign sdo      = r_shift[7];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_shift  <= 8'h00;
            r_bit    <= 3'd0;
            r_active <= 1'b0;
            r_sck    <= 1'b0;
        end else if (load) begin
            r_cnt    <= '0;
            r_shift  <= load_data;
            r_bit    <= 3'd0;
            r_active <= 1'b1;
            r_sck    <= 1'b0;
        end else if (r_active) begin
            if (r_cnt == c_CNT_MAX) begin
                r_cnt <= '0;
                if (!r_sck) begin
                    r_sck <= 1'b1;
                end else begin
                    r_sck   <= 1'b0;
                    r_shift <= {r_shift[6:0], 1'b0};
                    r_bit   <= r_bit + 3'd1;
                    if (r_bit == 3'd7)
                        r_active <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/osd_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : osd_spi_master
// Brief    : SPI initiator for OSD enable/disable and line-write commands.
// Revision : 1.0 - initial release
// ============================================================================
module osd_spi_master
    import osd_pkg::*;
#(
    parameter int SCK_DIV    = 4,
    parameter int SS_GAP     = 4,
    parameter int LINE_BYTES = OSD_LINE_BYTES
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [OSD_LINE_W-1:0] cmd_line,
    input  logic                  dat_valid,
    output logic                  dat_ready,
    input  logic [7:0]            dat_in,
    output logic                  busy,
    output logic                  SPI_SCK,
    output logic                  SPI_SS3,
    output logic                  SPI_DO
);

    localparam int                  c_WAIT_MAX   = (SCK_DIV > SS_GAP) ? SCK_DIV : SS_GAP;
    localparam int                  c_WAIT_W     = (c_WAIT_MAX > 1) ? $clog2(c_WAIT_MAX) : 1;
    localparam logic [c_WAIT_W-1:0] c_TAIL_END   = c_WAIT_W'(SCK_DIV - 1);
    localparam logic [c_WAIT_W-1:0] c_GAP_END    = c_WAIT_W'(SS_GAP - 1);
    localparam logic [8:0]          c_LINE_BYTES = 9'(LINE_BYTES);

    // SETUP keeps its encoding, but the shifter loads on the accept edge so
    // IDLE moves straight to SHIFT_LO with bit 7 already on the data line.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_FETCH    = 3'd4,
        ST_TAIL     = 3'd5,
        ST_GAP      = 3'd6
    } state_e;

    state_e              r_state;
    logic                r_cmd_ready;
    logic                r_dat_ready;
    logic                r_busy;
    logic                r_ss3;
    logic                r_is_write;
    logic [8:0]          r_byte_cnt;
    logic [c_WAIT_W-1:0] r_wait;

    osd_op_e    w_cmd_op;
    logic       w_start;
    logic       w_fetch_hs;
    logic       w_tx_load;
    logic [7:0] w_tx_data;
    logic       w_tx_half_end;
    logic       w_tx_last;

    assign w_cmd_op   = osd_op_e'(cmd_op);
    assign w_start    = r_cmd_ready && cmd_valid && (w_cmd_op != OP_RESERVED);
    assign w_fetch_hs = r_dat_ready && dat_valid;
    assign w_tx_load  = w_start || w_fetch_hs;
    assign w_tx_data  = w_start ? osd_cmd_byte(w_cmd_op, cmd_line) : dat_in;

    assign cmd_ready = r_cmd_ready;
    assign dat_ready = r_dat_ready;
    assign busy      = r_busy;
    assign SPI_SS3   = r_ss3;

    spi_tx_shift #(
        .SCK_DIV (SCK_DIV)
    ) u_tx (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .load      (w_tx_load),
        .load_data (w_tx_data),
        .sck       (SPI_SCK),
        .sdo       (SPI_DO),
        .half_end  (w_tx_half_end),
        .last_bit  (w_tx_last)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_dat_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_ss3       <= 1'b1;
            r_is_write  <= 1'b0;
            r_byte_cnt  <= 9'd0;
            r_wait      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_SHIFT_LO;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_ss3       <= 1'b0;
                        r_is_write  <= (w_cmd_op == OP_WRITE);
                        r_byte_cnt  <= 9'd0;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_tx_half_end)
                        r_state <= ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    if (w_tx_half_end) begin
                        if (!w_tx_last) begin
                            r_state <= ST_SHIFT_LO;
                        end else if (r_is_write && (r_byte_cnt < c_LINE_BYTES)) begin
                            r_state     <= ST_FETCH;
                            r_dat_ready <= 1'b1;
                        end else begin
                            r_state <= ST_TAIL;
                            r_wait  <= '0;
                        end
                    end
                end
                // SCK is parked low here, so stalling on the source is harmless.
                ST_FETCH: begin
                    if (w_fetch_hs) begin
                        r_state     <= ST_SHIFT_LO;
                        r_dat_ready <= 1'b0;
                        r_byte_cnt  <= r_byte_cnt + 9'd1;
                    end
                end
                ST_TAIL: begin
                    if (r_wait == c_TAIL_END) begin
                        r_state <= ST_GAP;
                        r_ss3   <= 1'b1;
                        r_wait  <= '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_wait == c_GAP_END) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_osd_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_osd_spi_master
// Brief    : Directed bench with an SCK-clocked OSD receiver model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_osd_spi_master;

    localparam int SCK_DIV    = 2;
    localparam int SS_GAP     = 4;
    localparam int LINE_BYTES = 256;

    logic       clk_sys   = 1'b0;
    logic       reset_n   = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = 2'd0;
    logic [2:0] cmd_line  = 3'd0;
    logic       dat_valid = 1'b0;
    logic [7:0] dat_in    = 8'h00;
    logic       cmd_ready, dat_ready, busy, SPI_SCK, SPI_SS3, SPI_DO;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    osd_spi_master #(
        .SCK_DIV    (SCK_DIV),
        .SS_GAP     (SS_GAP),
        .LINE_BYTES (LINE_BYTES)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_line  (cmd_line),
        .dat_valid (dat_valid),
        .dat_ready (dat_ready),
        .dat_in    (dat_in),
        .busy      (busy),
        .SPI_SCK   (SPI_SCK),
        .SPI_SS3   (SPI_SS3),
        .SPI_DO    (SPI_DO)
    );

    // Receiver model: samples on SCK rise, drops any partial byte when SS3 rises.
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_cmd = 8'h00;
    logic [7:0] rx_idx = 8'h00;
    logic [2:0] rx_line = 3'd0;
    logic       rx_first = 1'b1;
    logic       rx_wr = 1'b0;
    logic       osd_en = 1'b0;
    int         rx_bits = 0, rx_edges = 0, rx_last_edges = 0, rx_total = 0;
    logic [7:0] rx_buf [0:2047];
    logic [7:0] rx_byte;
    assign rx_byte = {rx_sh[6:0], SPI_DO};

    always @(posedge SPI_SCK or posedge SPI_SS3) begin
        if (SPI_SS3) begin
            rx_last_edges <= rx_edges;
            rx_edges      <= 0;
            rx_bits       <= 0;
            rx_first      <= 1'b1;
        end else begin
            rx_total <= rx_total + 1;
            rx_edges <= rx_edges + 1;
            rx_sh    <= rx_byte;
            if (rx_bits == 7) begin
                rx_bits  <= 0;
                rx_first <= 1'b0;
                if (rx_first) begin
                    rx_cmd <= rx_byte;
                    rx_wr  <= (rx_byte[7:3] == 5'b00100);
                    rx_line <= rx_byte[2:0];
                    rx_idx <= 8'h00;
                    if (rx_byte == 8'h40) osd_en <= 1'b0;
                    if (rx_byte == 8'h41) osd_en <= 1'b1;
                end else if (rx_wr) begin
                    rx_buf[{rx_line, rx_idx}] <= rx_byte;
                    rx_idx <= rx_idx + 8'h01;
                end
            end else begin
                rx_bits <= rx_bits + 1;
            end
        end
    end

    int hs_cnt = 0, hi_run = 0, last_gap = 0, dr_viol = 0;
    always @(posedge clk_sys) begin
        if (dat_valid && dat_ready) hs_cnt <= hs_cnt + 1;
    end
    always @(negedge clk_sys) begin
        if (SPI_SS3 === 1'b1) begin
            hi_run <= hi_run + 1;
        end else begin
            if (hi_run != 0) last_gap <= hi_run;
            hi_run <= 0;
        end
        if (dat_ready === 1'b1 && (SPI_SCK !== 1'b0 || SPI_SS3 !== 1'b0 || busy !== 1'b1))
            dr_viol <= dr_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [2:0] line);
        int t;
        t = 0;
        @(negedge clk_sys);
        cmd_op = op; cmd_line = line; cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && t < 50) begin @(negedge clk_sys); t++; end
        chk("cmd_accept_wait", 32'(t < 50), 32'd1);
        @(negedge clk_sys);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t, crv;
        t = 0; crv = 0;
        while (busy === 1'b1 && t < 20000) begin
            if (cmd_ready !== 1'b0) crv++;
            @(negedge clk_sys); t++;
        end
        chk({tag, "_busy_fall"}, 32'(t < 20000), 32'd1);
        chk({tag, "_cmd_ready_low"}, 32'(crv), 32'd0);
    endtask

    task automatic feed(input int n, input int stall_at, input int stall_cyc);
        int t, to, sv, e0;
        to = 0;
        for (int i = 0; i < n; i++) begin
            t = 0;
            if (i == stall_at) begin
                dat_valid = 1'b0;
                while (dat_ready !== 1'b1 && t < 1000) begin @(negedge clk_sys); t++; end
                e0 = rx_total; sv = 0;
                repeat (stall_cyc) begin
                    @(negedge clk_sys);
                    if (SPI_SCK !== 1'b0 || SPI_SS3 !== 1'b0 || dat_ready !== 1'b1) sv++;
                end
                chk("stall_lines_held", 32'(sv), 32'd0);
                chk("stall_no_sck_edges", 32'(rx_total - e0), 32'd0);
                t = 0;
            end
            dat_in = 8'(i); dat_valid = 1'b1;
            while (dat_ready !== 1'b1 && t < 1000) begin @(negedge clk_sys); t++; end
            if (t >= 1000) to++;
            @(negedge clk_sys);
        end
        dat_valid = 1'b0;
        chk("feed_no_timeout", 32'(to), 32'd0);
    endtask

    task automatic check_buf(input string tag, input logic [2:0] line);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (rx_buf[{line, 8'(i)}] !== 8'(i)) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int h0, e0, bz, t;

        // Reset state
        @(negedge clk_sys);
        chk("rst_sck", 32'(SPI_SCK), 32'd0);
        chk("rst_ss3", 32'(SPI_SS3), 32'd1);
        chk("rst_do", 32'(SPI_DO), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dat_ready", 32'(dat_ready), 32'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Enable
        send_cmd(2'd1, 3'd0);
        chk("en_busy_on_accept", 32'(busy), 32'd1);
        chk("en_ss3_low", 32'(SPI_SS3), 32'd0);
        wait_idle("en");
        chk("en_cmd_byte", 32'(rx_cmd), 32'h41);
        chk("en_edges", 32'(rx_last_edges), 32'd8);
        chk("en_osd_enable", 32'(osd_en), 32'd1);

        // Disable
        send_cmd(2'd0, 3'd0);
        wait_idle("dis");
        chk("dis_cmd_byte", 32'(rx_cmd), 32'h40);
        chk("dis_edges", 32'(rx_last_edges), 32'd8);
        chk("dis_osd_enable", 32'(osd_en), 32'd0);

        // Line 5 write, data always valid
        h0 = hs_cnt;
        send_cmd(2'd2, 3'd5);
        feed(256, -1, 0);
        wait_idle("wr5");
        chk("wr5_cmd_byte", 32'(rx_cmd), 32'h25);
        chk("wr5_edges", 32'(rx_last_edges), 32'd2056);
        chk("wr5_handshakes", 32'(hs_cnt - h0), 32'd256);
        check_buf("wr5_buffer", 3'd5);

        // Line 2 write with a 50-cycle source stall before byte 10
        h0 = hs_cnt;
        send_cmd(2'd2, 3'd2);
        feed(256, 10, 50);
        wait_idle("wr2");
        chk("wr2_cmd_byte", 32'(rx_cmd), 32'h22);
        chk("wr2_edges", 32'(rx_last_edges), 32'd2056);
        chk("wr2_handshakes", 32'(hs_cnt - h0), 32'd256);
        check_buf("wr2_buffer", 3'd2);

        // Reset during byte 100 of a write (byte 0x63: SCK high with DO=1 six cycles in)
        send_cmd(2'd2, 3'd3);
        feed(100, -1, 0);
        repeat (6) @(negedge clk_sys);
        chk("pre_rst_ss3", 32'(SPI_SS3), 32'd0);
        chk("pre_rst_sck", 32'(SPI_SCK), 32'd1);
        chk("pre_rst_do", 32'(SPI_DO), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_ss3", 32'(SPI_SS3), 32'd1);
        chk("abort_sck", 32'(SPI_SCK), 32'd0);
        chk("abort_do", 32'(SPI_DO), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dat_ready", 32'(dat_ready), 32'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        send_cmd(2'd1, 3'd0);
        wait_idle("post_abort_en");
        chk("post_abort_cmd_byte", 32'(rx_cmd), 32'h41);
        chk("post_abort_edges", 32'(rx_last_edges), 32'd8);
        chk("post_abort_osd_enable", 32'(osd_en), 32'd1);

        // Back-to-back enable then line 7 write, cmd_valid held high
        @(negedge clk_sys);
        cmd_op = 2'd1; cmd_valid = 1'b1;
        @(negedge clk_sys);
        cmd_op = 2'd2; cmd_line = 3'd7;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 1000) begin @(negedge clk_sys); t++; end
        chk("b2b_en_done", 32'(t < 1000), 32'd1);
        chk("b2b_en_cmd_byte", 32'(rx_cmd), 32'h41);
        chk("b2b_en_edges", 32'(rx_last_edges), 32'd8);
        @(negedge clk_sys);
        cmd_valid = 1'b0;
        h0 = hs_cnt;
        feed(256, -1, 0);
        wait_idle("b2b_wr");
        chk("b2b_gap_min", 32'(last_gap >= SS_GAP), 32'd1);
        chk("b2b_gap_tight", 32'(last_gap <= SS_GAP + 2), 32'd1);
        chk("b2b_wr_cmd_byte", 32'(rx_cmd), 32'h27);
        chk("b2b_wr_edges", 32'(rx_last_edges), 32'd2056);
        chk("b2b_wr_handshakes", 32'(hs_cnt - h0), 32'd256);
        check_buf("b2b_wr_buffer", 3'd7);

        // Reserved op: accepted, no SPI activity
        e0 = rx_total;
        send_cmd(2'd3, 3'd0);
        bz = 0;
        repeat (20) begin
            @(negedge clk_sys);
            if (busy !== 1'b0 || SPI_SS3 !== 1'b1) bz++;
        end
        chk("op3_idle", 32'(bz), 32'd0);
        chk("op3_no_edges", 32'(rx_total - e0), 32'd0);
        chk("op3_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("dat_ready_only_in_fetch", 32'(dr_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
